// File: rtl/mem_access_unit_pkg.sv
// Shared parameters for the RAMblock initiator: bus widths, RAM depth and
// the 2-bit FSM encodings so that the control unit and benches can decode state.
package mem_access_unit_pkg;

    localparam int mau_adlines   = 8;
    localparam int mau_datalines = 8;
    localparam int mau_ramsize   = 256;
    localparam int mau_waitwidth = 4;

    localparam logic [1:0] st_idle    = 2'd0;
    localparam logic [1:0] st_setup   = 2'd1;
    localparam logic [1:0] st_access  = 2'd2;
    localparam logic [1:0] st_recover = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = st_idle,
        SETUP   = st_setup,
        ACCESS  = st_access,
        RECOVER = st_recover
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Single-request load/store initiator for RAMblock: address/data setup,
// strobe held for WAITCYCLES+1 cycles, one recovery cycle with a response pulse.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int adlines    = mau_adlines,
    parameter int datalines  = mau_datalines,
    parameter int ramsize    = mau_ramsize,
    parameter int WAITCYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [adlines-1:0]   req_addr,
    input  logic [datalines-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [datalines-1:0] rsp_rdata,
    output logic [adlines-1:0]   ram_address,
    output logic [datalines-1:0] ram_datain,
    input  logic [datalines-1:0] ram_dataout,
    output logic                 ram_read,
    output logic                 ram_write,
    output logic                 busy
);

    if (WAITCYCLES < 0 || WAITCYCLES > 15) begin : g_waitcycles_range
        $error("mem_access_unit: WAITCYCLES must be in 0..15");
    end

    localparam logic [mau_waitwidth-1:0] waitload = mau_waitwidth'(WAITCYCLES);

    mau_state_t               state;
    mau_state_t               next_state;
    logic                     wr_flag;
    logic                     err_flag;
    logic [mau_waitwidth-1:0] waitcnt;
    logic                     accept;
    logic                     in_range;
    logic                     access_done;

    assign accept      = req_valid && req_ready;
    assign in_range    = 32'(req_addr) < 32'(ramsize);
    assign access_done = (state == ACCESS) && (waitcnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Out-of-range requests skip the RAM entirely and go straight to the response cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = in_range ? SETUP : RECOVER;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (waitcnt == '0) next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == RECOVER);
        rsp_err   = (state == RECOVER) && err_flag;
    end

    // Strobes are registered from next_state so the RAM never sees a decode glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_flag     <= 1'b0;
            err_flag    <= 1'b0;
            waitcnt     <= '0;
            ram_address <= '0;
            ram_datain  <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            if (accept) begin
                if (in_range) begin
                    wr_flag     <= req_write;
                    ram_address <= req_addr;
                    ram_datain  <= req_wdata;
                end else begin
                    err_flag <= 1'b1;
                end
            end

            if (state == SETUP) begin
                waitcnt <= waitload;
            end else if ((state == ACCESS) && (waitcnt != '0)) begin
                waitcnt <= waitcnt - 1'b1;
            end

            ram_write <= (next_state == ACCESS) && wr_flag;
            ram_read  <= (next_state == ACCESS) && !wr_flag;

            if (access_done && !wr_flag) begin
                rsp_rdata <= ram_dataout;
            end

            if (state == RECOVER) begin
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (WAITCYCLES=0/ramsize=256 and
// WAITCYCLES=3/ramsize=200) against a RAM model and a transaction-level reference.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       memInit;
    logic       sel;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;

    logic [1:0] rvA, rdyA, rspvA, errA, rdA, wrA, busyA;
    logic [7:0] rdataA[2];
    logic [7:0] addrA[2];
    logic [7:0] dinA[2];
    logic [7:0] doutA[2];
    logic [7:0] ram[2][256];

    logic [7:0] refmem[2][256];
    logic [7:0] expRdata[2];
    logic [7:0] lastAddr[2];
    logic [7:0] lastDin[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rvA[0] = req_valid && (sel == 1'b0);
    assign rvA[1] = req_valid && (sel == 1'b1);

    mem_access_unit #(.adlines(8), .datalines(8), .ramsize(256), .WAITCYCLES(0)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(rvA[0]), .req_ready(rdyA[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspvA[0]), .rsp_err(errA[0]), .rsp_rdata(rdataA[0]),
        .ram_address(addrA[0]), .ram_datain(dinA[0]), .ram_dataout(doutA[0]),
        .ram_read(rdA[0]), .ram_write(wrA[0]), .busy(busyA[0])
    );

    mem_access_unit #(.adlines(8), .datalines(8), .ramsize(200), .WAITCYCLES(3)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(rvA[1]), .req_ready(rdyA[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspvA[1]), .rsp_err(errA[1]), .rsp_rdata(rdataA[1]),
        .ram_address(addrA[1]), .ram_datain(dinA[1]), .ram_dataout(doutA[1]),
        .ram_read(rdA[1]), .ram_write(wrA[1]), .busy(busyA[1])
    );

    // Level-sensitive RAMblock stand-in: writes while the strobe is high, reads combinationally.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (memInit) begin
                for (int j = 0; j < 256; j++) ram[i][j] <= 8'h00;
            end else if (wrA[i]) begin
                ram[i][addrA[i]] <= dinA[i];
            end
        end
    end
    assign doutA[0] = ram[0][addrA[0]];
    assign doutA[1] = ram[1][addrA[1]];

    logic       req_ready_m, rspv_m, err_m, rd_m, wr_m, busy_m;
    logic [7:0] rdata_m, addr_m, din_m;
    assign req_ready_m = rdyA[sel];
    assign rspv_m      = rspvA[sel];
    assign err_m       = errA[sel];
    assign rd_m        = rdA[sel];
    assign wr_m        = wrA[sel];
    assign busy_m      = busyA[sel];
    assign rdata_m     = rdataA[sel];
    assign addr_m      = addrA[sel];
    assign din_m       = dinA[sel];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!req_ready_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_req", 32'(req_ready_m), 32'd1);
    endtask

    // One complete transaction on the selected instance, checked against the reference.
    task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int         wc = sel ? 3 : 0;
        int         rs = sel ? 200 : 256;
        logic       inr;
        int         lat = 0, wcnt = 0, rcnt = 0, addrBad = 0, dinBad = 0;
        logic [7:0] expA, expD;
        logic       errObs = 1'b0;
        logic [7:0] rdObs = 8'h00;
        inr = int'(a) < rs;
        waitReady();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        expA = inr ? a : lastAddr[sel];
        expD = inr ? d : lastDin[sel];
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            wcnt += int'(wr_m);
            rcnt += int'(rd_m);
            if (addr_m !== expA) addrBad++;
            if (din_m !== expD) dinBad++;
            if (rspv_m) begin
                lat    = k;
                errObs = err_m;
                rdObs  = rdata_m;
                break;
            end
        end
        if (inr) begin
            lastAddr[sel] = a;
            lastDin[sel]  = d;
            if (wr) refmem[sel][a] = d;
            else    expRdata[sel]  = refmem[sel][a];
        end
        checkOutput("latency", 32'(lat), inr ? 32'(wc + 3) : 32'd1);
        checkOutput("rsp_err", 32'(errObs), 32'(!inr));
        checkOutput("rsp_rdata", 32'(rdObs), 32'(expRdata[sel]));
        checkOutput("write_cycles", 32'(wcnt), (inr && wr) ? 32'(wc + 1) : 32'd0);
        checkOutput("read_cycles", 32'(rcnt), (inr && !wr) ? 32'(wc + 1) : 32'd0);
        checkOutput("addr_stable", 32'(addrBad), 32'd0);
        checkOutput("datain_stable", 32'(dinBad), 32'd0);
        @(negedge clk);
        checkOutput("rsp_pulse_end", 32'(rspv_m), 32'd0);
        checkOutput("ready_after_rsp", 32'(req_ready_m), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         cyc, lastAcc, got;
        logic       wr;
        logic [7:0] a, d, expRd;

        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) refmem[i][j] = 8'h00;
            expRdata[i] = 8'h00;
            lastAddr[i] = 8'h00;
            lastDin[i]  = 8'h00;
        end
        reset     = 1'b1;
        memInit   = 1'b1;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;

        // Reset state on both instances.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checkOutput("rst_ram_read", 32'(rd_m), 32'd0);
            checkOutput("rst_ram_write", 32'(wr_m), 32'd0);
            checkOutput("rst_ram_address", 32'(addr_m), 32'd0);
            checkOutput("rst_ram_datain", 32'(din_m), 32'd0);
            checkOutput("rst_rsp_valid", 32'(rspv_m), 32'd0);
            checkOutput("rst_rsp_err", 32'(err_m), 32'd0);
            checkOutput("rst_rsp_rdata", 32'(rdata_m), 32'd0);
            checkOutput("rst_busy", 32'(busy_m), 32'd0);
        end
        @(negedge clk);
        reset   = 1'b0;
        memInit = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset0", 32'(rdyA[0]), 32'd1);
        checkOutput("ready_after_reset1", 32'(rdyA[1]), 32'd1);

        // Zero wait states: store then load back.
        sel = 1'b0;
        applyStimulus(1'b1, 8'h10, 8'h5A);
        applyStimulus(1'b0, 8'h10, 8'h00);

        // Three wait states: pre-write 0xC3 then load it.
        sel = 1'b1;
        applyStimulus(1'b1, 8'h20, 8'hC3);
        applyStimulus(1'b0, 8'h20, 8'h77);

        // Out-of-range load on the 200-word instance keeps the old read data.
        applyStimulus(1'b0, 8'hF0, 8'h00);
        checkOutput("err_keeps_rdata", 32'(rdata_m), 32'hC3);

        // req_valid held high with alternating store/load: fixed request spacing.
        sel = 1'b1;
        waitReady();
        req_valid = 1'b1;
        cyc = 0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            wr = (i % 2 == 0);
            a  = 8'(1 + i / 2);
            d  = 8'($urandom_range(0, 255));
            req_write = wr;
            req_addr  = a;
            req_wdata = d;
            lastAddr[1] = a;
            lastDin[1]  = d;
            if (wr) refmem[1][a] = d;
            else    expRdata[1]  = refmem[1][a];
            expRd   = expRdata[1];
            lastAcc = cyc;
            do begin
                @(negedge clk);
                cyc++;
                if (rspv_m) begin
                    got++;
                    checkOutput("b2b_rdata", 32'(rdata_m), 32'(expRd));
                    checkOutput("b2b_err", 32'(err_m), 32'd0);
                end
            end while (!req_ready_m && (cyc - lastAcc) < 40);
            checkOutput("b2b_spacing", 32'(cyc - lastAcc), 32'd7);
        end
        req_valid = 1'b0;
        checkOutput("b2b_count", 32'(got), 32'd8);

        // Randomised mix on both instances, biased towards reused and boundary addresses.
        repeat (40) begin
            sel = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 255));
                1:       a = 8'(8'h10 + $urandom_range(0, 3));
                2:       a = 8'(198 + $urandom_range(0, 3));
                default: a = 8'($urandom_range(250, 255));
            endcase
            applyStimulus(wr, a, d);
        end

        // Reset during the second ACCESS cycle of a store on the 3-wait instance.
        sel = 1'b1;
        waitReady();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h7F;
        req_wdata = 8'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_write_before", 32'(wr_m), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_write_drop", 32'(wr_m), 32'd0);
        checkOutput("abort_busy", 32'(busy_m), 32'd0);
        got = 0;
        repeat (2) begin
            @(negedge clk);
            got += int'(rspv_m);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expRdata[i] = 8'h00;
            lastAddr[i] = 8'h00;
            lastDin[i]  = 8'h00;
        end
        @(negedge clk);
        got += int'(rspv_m);
        checkOutput("abort_no_rsp", 32'(got), 32'd0);
        checkOutput("abort_ready", 32'(req_ready_m), 32'd1);
        checkOutput("abort_no_strobe", 32'(wr_m | rd_m), 32'd0);
        applyStimulus(1'b0, 8'h20, 8'h00);
        checkOutput("abort_then_load", 32'(rdata_m), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
